// File: rtl/idct_scheduler.sv
// idct_scheduler: credit-limited issue of coefficient blocks to an IDCT
// datapath, in-order result buffering, MCU block tagging, flush and error flag.
module idct_scheduler #(
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned BLOCKS_PER_MCU = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [511:0] s_data,
  output logic         idct_s_valid,
  output logic [511:0] idct_data_in,
  input  logic         idct_m_valid,
  input  logic [511:0] idct_data_out,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [511:0] m_data,
  output logic [2:0]   m_tag,
  output logic         m_last,
  input  logic         flush,
  output logic         flush_done,
  output logic         err
);

  localparam int unsigned DW = 512;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            run_c;
  logic            tag_clr_c;

  logic [CW-1:0]   inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [DW-1:0]   mem [DEPTH];

  logic            accept;
  logic            pop;
  logic            full;
  logic            res_dec;
  logic            wr_en;
  logic            drop;

  // Handshake and buffer-write qualification
  assign occ     = {1'b0, inflight} + {1'b0, count};
  assign s_ready = run_c && (occ < (CW+1)'(DEPTH));
  assign accept  = s_valid && s_ready;
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  assign full    = (count == CW'(DEPTH));
  // A full buffer can still take a result when the head leaves in the same cycle
  assign wr_en   = idct_m_valid && (!full || pop);
  assign drop    = idct_m_valid && full && !pop;
  assign res_dec = idct_m_valid && (inflight != '0);
  assign m_data  = mem[rd_ptr];
  assign m_last  = m_valid && (m_tag == TW'(BLOCKS_PER_MCU - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush) state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight == '0 && count == '0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // FSM output decode
  always_comb begin
    run_c      = 1'b0;
    tag_clr_c  = 1'b0;
    flush_done = 1'b0;
    case (state)
      ST_RUN:  run_c = 1'b1;
      ST_DONE: begin
        flush_done = 1'b1;
        tag_clr_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Issue register: one-cycle strobe, data held between issues
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idct_s_valid <= 1'b0;
      idct_data_in <= '0;
    end else begin
      idct_s_valid <= accept;
      if (accept) idct_data_in <= s_data;
    end
  end

  // In-flight credit counter; a stray result with nothing in flight is not counted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else if (accept && !res_dec) begin
      inflight <= inflight + CW'(1);
    end else if (!accept && res_dec) begin
      inflight <= inflight - CW'(1);
    end
  end

  // Buffer occupancy and circular pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !pop)      count <= count + CW'(1);
      else if (!wr_en && pop) count <= count - CW'(1);
      if (wr_en) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)   rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end
  end

  // Result storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= idct_data_out;
  end

  // Block-within-MCU tag, restarted after every completed flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tag <= '0;
    end else if (tag_clr_c) begin
      m_tag <= '0;
    end else if (pop) begin
      m_tag <= (m_tag == TW'(BLOCKS_PER_MCU - 1)) ? '0 : m_tag + TW'(1);
    end
  end

  // Sticky protocol error: unexpected result or result into a full buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (idct_m_valid && ((inflight == '0) || drop)) begin
      err <= 1'b1;
    end
  end

endmodule
